// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch for the single-issue RV32I core.
// Owns the PC, issues word fetches under a credit limit, and buffers returned
// words with their PCs in a small FIFO feeding decode. A redirect flushes the
// buffer and discards every response still owed by memory.
// Optional feature: define IFETCH_MISALIGN_CHECK_EN to flag misaligned redirect
// targets (sticky oMisalign, fetch halted until the next aligned redirect).
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        iClk,
   input  logic        iRst_n,
   output logic        oImemReqValid,
   input  logic        iImemReqReady,
   output logic [31:0] oImemReqAddr,
   input  logic        iImemRspValid,
   input  logic [31:0] iImemRspData,
   output logic        oInstrValid,
   input  logic        iInstrReady,
   output logic [31:0] oInstr,
   output logic [31:0] oInstrPc,
   input  logic        iRedirect,
   input  logic [31:0] iRedirectPc,
   output logic        oMisalign
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = CNT_W + 1;

`ifdef IFETCH_MISALIGN_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   // Control state
   logic [31:0]      pc;
   logic [PTR_W-1:0] fifo_wr;
   logic [PTR_W-1:0] fifo_rd;
   logic [PTR_W-1:0] tag_wr;
   logic [PTR_W-1:0] tag_rd;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] drop;
   logic             misalign;

   // Storage (data only, never reset)
   logic [31:0] fifo_data [FIFO_DEPTH];
   logic [31:0] fifo_pc   [FIFO_DEPTH];
   logic [31:0] tag_q     [FIFO_DEPTH];

   logic             halted;
   logic             credit_ok;
   logic             req_hs;
   logic             rsp_keep;
   logic             pop;
   logic             redirect_bad;
   logic [CNT_W-1:0] inflight_next;
   logic [31:0]      redirect_target;

   // A halted unit is one parked on a misaligned redirect target.
   assign halted = misalign;

   // Every outstanding request must have a guaranteed FIFO slot for its response.
   assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < SUM_W'(FIFO_DEPTH);

   // Requests are masked while reset is held so the channel is idle during reset.
   assign oImemReqValid = iRst_n && credit_ok && !halted;
   assign oImemReqAddr  = pc;

   assign req_hs   = oImemReqValid && iImemReqReady;
   assign rsp_keep = iImemRspValid && (drop == '0);
   assign pop      = oInstrValid && iInstrReady;

   // Outstanding requests after this cycle: responses arriving now are no longer owed.
   assign inflight_next = inflight + CNT_W'(req_hs) - CNT_W'(iImemRspValid);

   // Low address bits only matter when misalignment checking is built in.
   assign redirect_bad    = CHECK_EN && (iRedirectPc[1:0] != 2'b00);
   assign redirect_target = {iRedirectPc[31:2], 2'b00};

   // Head of the FIFO is presented to decode; zero when empty keeps outputs clean.
   assign oInstrValid = (fifo_count != '0);
   assign oInstr      = oInstrValid ? fifo_data[fifo_rd] : 32'h0;
   assign oInstrPc    = oInstrValid ? fifo_pc[fifo_rd]   : 32'h0;
   assign oMisalign   = misalign;

   // Control state: PC, pointers, counters; redirect overrides all other updates.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         pc         <= RESET_PC;
         fifo_wr    <= '0;
         fifo_rd    <= '0;
         tag_wr     <= '0;
         tag_rd     <= '0;
         fifo_count <= '0;
         inflight   <= '0;
         drop       <= '0;
         misalign   <= 1'b0;
      end else if (iRedirect) begin
         // Everything still owed by memory (including a request accepted now) is stale.
         pc         <= redirect_target;
         fifo_wr    <= '0;
         fifo_rd    <= '0;
         tag_wr     <= '0;
         tag_rd     <= '0;
         fifo_count <= '0;
         inflight   <= inflight_next;
         drop       <= inflight_next;
         misalign   <= redirect_bad;
      end else begin
         if (req_hs) begin
            pc     <= pc + 32'd4;
            tag_wr <= tag_wr + PTR_W'(1);
         end
         if (rsp_keep) begin
            fifo_wr <= fifo_wr + PTR_W'(1);
            tag_rd  <= tag_rd + PTR_W'(1);
         end
         if (pop) begin
            fifo_rd <= fifo_rd + PTR_W'(1);
         end
         fifo_count <= fifo_count + CNT_W'(rsp_keep) - CNT_W'(pop);
         inflight   <= inflight_next;
         if (iImemRspValid && (drop != '0)) begin
            drop <= drop - CNT_W'(1);
         end
      end
   end

   // Storage writes: PC tags for accepted requests, words paired with their tags.
   always_ff @(posedge iClk) begin
      if (req_hs) begin
         tag_q[tag_wr] <= pc;
      end
      if (rsp_keep && !iRedirect) begin
         fifo_data[fifo_wr] <= iImemRspData;
         fifo_pc[fifo_wr]   <= tag_q[tag_rd];
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed phases followed by randomized traffic against a
// stream-level reference (expected fetch/decode PC streams, epoch-tagged memory).
module tb_ifetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          D        = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        oImemReqValid;
   logic        iImemReqReady = 1'b0;
   logic [31:0] oImemReqAddr;
   logic        iImemRspValid = 1'b0;
   logic [31:0] iImemRspData = 32'h0;
   logic        oInstrValid;
   logic        iInstrReady = 1'b0;
   logic [31:0] oInstr;
   logic [31:0] oInstrPc;
   logic        iRedirect = 1'b0;
   logic [31:0] iRedirectPc = 32'h0;
   logic        oMisalign;

   always #5 clk = ~clk;

   ifetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(D)) dut (
      .iClk(clk), .iRst_n(rst_n),
      .oImemReqValid(oImemReqValid), .iImemReqReady(iImemReqReady), .oImemReqAddr(oImemReqAddr),
      .iImemRspValid(iImemRspValid), .iImemRspData(iImemRspData),
      .oInstrValid(oInstrValid), .iInstrReady(iInstrReady), .oInstr(oInstr), .oInstrPc(oInstrPc),
      .iRedirect(iRedirect), .iRedirectPc(iRedirectPc), .oMisalign(oMisalign)
   );

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } mreq_t;

   mreq_t       mem_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc, epoch, buffered, lat_min, lat_max;
   int          first_valid_cyc, req_count, saw_addr0;
   logic [31:0] exp_fetch, exp_dec;
   bit          exp_halt, exp_mis, prev_stall;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a ^ 32'h5A5A_A5A5) + {a[7:0], a[31:8]} + 32'h0001_0003;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mem_q.delete();
      epoch = 0; buffered = 0; cyc = 0;
      exp_fetch = RESET_PC; exp_dec = RESET_PC;
      exp_halt = 1'b0; exp_mis = 1'b0; prev_stall = 1'b0;
      first_valid_cyc = 0; req_count = 0; saw_addr0 = 0;
   endtask

   // Called at posedge+1; asserts reset mid-cycle, checks reset outputs, releases at posedge+1.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req_valid", oImemReqValid, 0);
      chk("rst_req_addr", oImemReqAddr, RESET_PC);
      chk("rst_instr_valid", oInstrValid, 0);
      chk("rst_instr", oInstr, 0);
      chk("rst_instr_pc", oInstrPc, 0);
      chk("rst_misalign", oMisalign, 0);
      iImemReqReady = 1'b0; iImemRspValid = 1'b0; iInstrReady = 1'b0; iRedirect = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // One clock cycle: drive at posedge+1, check and update the model at negedge.
   task automatic step(input bit mrdy, input bit drdy, input bit redir, input logic [31:0] rpc);
      bit rsp, req_hs, dec_hs, exp_rv;
      int due;
      cyc++;
      iImemReqReady = mrdy; iInstrReady = drdy; iRedirect = redir; iRedirectPc = rpc;
      rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
      iImemRspValid = rsp;
      iImemRspData  = rsp ? mem_word(mem_q[0].addr) : $urandom;
      @(negedge clk);
      exp_rv = ((mem_q.size() + buffered) < D) && !exp_halt;
      chk("req_valid", oImemReqValid, exp_rv);
      if (oImemReqValid) chk("req_addr", oImemReqAddr, exp_fetch);
      if (prev_stall) chk("req_hold", oImemReqValid, 1);
      chk("instr_valid", oInstrValid, buffered != 0);
      chk("misalign", oMisalign, exp_mis);
      if (oInstrValid) begin
         chk("instr_pc", oInstrPc, exp_dec);
         chk("instr_data", oInstr, mem_word(exp_dec));
         if (first_valid_cyc == 0) first_valid_cyc = cyc;
      end
      req_hs = oImemReqValid && mrdy;
      dec_hs = oInstrValid && drdy;
      if (dec_hs) begin
         exp_dec += 32'd4;
         buffered--;
      end
      if (rsp) begin
         if (mem_q[0].epoch == epoch) buffered++;
         void'(mem_q.pop_front());
      end
      if (req_hs) begin
         due = cyc + $urandom_range(lat_min, lat_max);
         if (mem_q.size() != 0 && mem_q[$].due >= due) due = mem_q[$].due + 1;
         mem_q.push_back('{addr: oImemReqAddr, epoch: epoch, due: due});
         req_count++;
         if (oImemReqAddr == 32'h0) saw_addr0 = 1;
         exp_fetch += 32'd4;
      end
      if (redir) begin
         epoch++;
         buffered = 0;
`ifdef IFETCH_MISALIGN_CHECK_EN
         exp_halt = (rpc[1:0] != 2'b00);
         exp_mis  = exp_halt;
`endif
         exp_fetch = {rpc[31:2], 2'b00};
         exp_dec   = exp_fetch;
      end
      prev_stall = oImemReqValid && !mrdy && !redir;
      @(posedge clk); #1;
   endtask

   initial begin
      bit fired;
      // Reset and first fetches, memory latency 1, decode always ready
      #1 rst_n = 1'b0;
      #1;
      chk("rst0_req_valid", oImemReqValid, 0);
      chk("rst0_instr_valid", oInstrValid, 0);
      chk("rst0_instr", oInstr, 0);
      chk("rst0_instr_pc", oInstrPc, 0);
      chk("rst0_misalign", oMisalign, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("first_valid_cycle", first_valid_cyc, 3);

      // Decode stalled for 10 cycles: only two requests fit, then drain in order
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_reqs", req_count, 2);
      chk("stall_head_pc", oInstrPc, 32'h0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

      // Memory not ready: request must hold address 0x8
      do_reset();
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("hold_valid", oImemReqValid, 1);
      chk("hold_addr", oImemReqAddr, 32'h8);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect with two requests outstanding and one response arriving
      do_reset();
      lat_min = 2; lat_max = 2;
      fired = 1'b0;
      for (int i = 0; i < 20 && !fired; i++) begin
         if (mem_q.size() == 2 && mem_q[0].due <= cyc + 1) begin
            step(1'b0, 1'b1, 1'b1, 32'h100);
            fired = 1'b1;
         end else begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
         end
      end
      chk("redir_fired", fired, 1);
      chk("redir_instr_valid", oInstrValid, 0);
      chk("redir_addr", oImemReqAddr, 32'h100);
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

      // PC wrap at the top of the address space
      step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      saw_addr0 = 0;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("wrap_fetch0", saw_addr0, 1);

      // Misaligned redirect target
      step(1'b1, 1'b1, 1'b1, 32'h102);
`ifdef IFETCH_MISALIGN_CHECK_EN
      chk("mis_flag", oMisalign, 1);
      chk("mis_no_req", oImemReqValid, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h200);
      chk("mis_clear", oMisalign, 0);
      chk("mis_resume_addr", oImemReqAddr, 32'h200);
`else
      chk("mis_flag", oMisalign, 0);
      chk("mis_aligned_addr", oImemReqAddr, 32'h100);
`endif
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

      // Randomized traffic with variable memory latency and a mid-run reset
      lat_min = 1; lat_max = 3;
      for (int i = 0; i < 3000; i++) begin
         bit          mis;
         logic [31:0] rpc;
         if (i == 1500) begin
            do_reset();
            lat_min = 1; lat_max = 3;
         end
         mis = ($urandom_range(0, 3) == 0);
         rpc = $urandom & (mis ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 24) == 0, rpc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
